// File: rtl/isp_uart_rx_pkg.sv
// isp_uart_rx_pkg: shared types and constants for the ISP-UART receive front-end.
//   state_e    : receiver FSM states
//   OVERSAMPLE : subticks per bit period
//   DATA_BITS  : data bits per 8N1 frame
//   maj3       : 2-of-3 majority vote
package isp_uart_rx_pkg;

  localparam int unsigned OVERSAMPLE = 4;
  localparam int unsigned DATA_BITS  = 8;

  typedef enum logic [2:0] {
    StWaitIdle,
    StIdle,
    StStart,
    StData,
    StStop
  } state_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: synchronous first-word-fall-through FIFO.
//   clk, rstn : clock, asynchronous active-low reset
//   push, din : write request and data (ignored when full unless popping)
//   pop       : read request (ignored when empty)
//   dout      : head entry, valid whenever !empty
//   empty,full: occupancy flags
module uart_rx_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic [WIDTH-1:0] dout,
  output logic             empty,
  output logic             full
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr_q, rd_ptr_q;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             do_push, do_pop;

  // Extra pointer MSB tells a wrapped (full) pointer pair from an equal (empty) one.
  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  assign do_pop  = pop && !empty;
  // While full, a write is only accepted when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);

  assign dout = mem_q[rd_ptr_q[AW-1:0]];

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= din;
        wr_ptr_q                <= wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
      end
    end
  end

endmodule

// File: rtl/isp_uart_rx.sv
// isp_uart_rx: ISP-UART 8N1 receive front-end with 4x oversampling and FIFO.
//   clk       : system clock
//   rstn      : asynchronous active-low reset
//   rx        : raw RX pin, asynchronous, idle high
//   rx_data   : FIFO head byte (first-word fall-through)
//   rx_valid  : FIFO non-empty
//   rx_ready  : consumer takes the head byte this cycle
//   frame_err : 1-cycle pulse, stop bit sampled low
//   overflow  : 1-cycle pulse, byte completed while FIFO full and not popping
//   rx_busy   : FSM not idle
module isp_uart_rx
  import isp_uart_rx_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 108,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       rx,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       frame_err,
  output logic       overflow,
  output logic       rx_busy
);

  localparam int unsigned CntW = $clog2(CLK_DIV);
  localparam int unsigned IdxW = $clog2(OVERSAMPLE);
  localparam int unsigned BitW = $clog2(DATA_BITS);

  localparam logic [CntW-1:0] CntLast = CntW'(CLK_DIV - 1);
  localparam logic [IdxW-1:0] IdxLast = IdxW'(OVERSAMPLE - 1);
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_BITS - 1);

  state_e               state_q;
  logic [1:0]           sync_q, sync_vld_q;
  logic [CntW-1:0]      sub_cnt_q;
  logic [IdxW-1:0]      sub_idx_q;
  logic [BitW-1:0]      bit_cnt_q;
  logic [1:0]           samp_q;
  logic                 vote_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 frame_err_q, overflow_q;

  logic rx_s, rx_s_vld, sub_end, bit_end, stop_end, vote_now;
  logic push, pop, fifo_empty, fifo_full;

  // Synchroniser flops reset to 1, so the first two post-reset values are not real line
  // observations; rx_s_vld keeps WAIT_IDLE from mistaking them for an idle line.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_q     <= 2'b11;
      sync_vld_q <= 2'b00;
    end else begin
      sync_q     <= {sync_q[0], rx};
      sync_vld_q <= {sync_vld_q[0], 1'b1};
    end
  end

  assign rx_s     = sync_q[1];
  assign rx_s_vld = sync_vld_q[1];

  assign sub_end  = (sub_cnt_q == CntLast);
  assign bit_end  = sub_end && (sub_idx_q == IdxLast);
  // Stop bit is judged on its third sample, leaving slack for a fast sender's next start.
  assign stop_end = (state_q == StStop) && sub_end && (sub_idx_q == IdxW'(2));
  assign vote_now = maj3(samp_q[0], samp_q[1], rx_s);

  assign push = stop_end && vote_now;
  assign pop  = rx_valid && rx_ready;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q     <= StWaitIdle;
      sub_cnt_q   <= '0;
      sub_idx_q   <= '0;
      bit_cnt_q   <= '0;
      samp_q      <= '0;
      vote_q      <= 1'b0;
      shift_q     <= '0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overflow_q  <= push && fifo_full && !pop;

      // Oversample timing runs only while a frame is in progress.
      if (state_q == StStart || state_q == StData || state_q == StStop) begin
        if (sub_end) begin
          sub_cnt_q <= '0;
          sub_idx_q <= sub_idx_q + 1'b1;
          if (sub_idx_q == IdxW'(0)) begin
            samp_q[0] <= rx_s;
          end else if (sub_idx_q == IdxW'(1)) begin
            samp_q[1] <= rx_s;
          end else if (sub_idx_q == IdxW'(2)) begin
            vote_q <= vote_now;
          end
        end else begin
          sub_cnt_q <= sub_cnt_q + 1'b1;
        end
      end else begin
        sub_cnt_q <= '0;
        sub_idx_q <= '0;
      end

      case (state_q)
        StWaitIdle: begin
          if (rx_s_vld && rx_s) state_q <= StIdle;
        end
        StIdle: begin
          if (!rx_s) state_q <= StStart;
        end
        StStart: begin
          if (bit_end) begin
            if (vote_q) begin
              state_q <= StIdle;
            end else begin
              state_q   <= StData;
              bit_cnt_q <= '0;
            end
          end
        end
        StData: begin
          if (bit_end) begin
            shift_q <= {vote_q, shift_q[DATA_BITS-1:1]};
            if (bit_cnt_q == BitLast) begin
              state_q <= StStop;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end
        end
        StStop: begin
          if (stop_end) begin
            if (vote_now) begin
              state_q <= StIdle;
            end else begin
              frame_err_q <= 1'b1;
              state_q     <= StWaitIdle;
            end
          end
        end
        default: state_q <= StWaitIdle;
      endcase
    end
  end

  uart_rx_fifo #(
    .DEPTH(FIFO_DEPTH),
    .WIDTH(DATA_BITS)
  ) u_fifo (
    .clk  (clk),
    .rstn (rstn),
    .push (push),
    .din  (shift_q),
    .pop  (pop),
    .dout (rx_data),
    .empty(fifo_empty),
    .full (fifo_full)
  );

  assign rx_valid  = !fifo_empty;
  assign frame_err = frame_err_q;
  assign overflow  = overflow_q;
  assign rx_busy   = (state_q != StIdle);

endmodule

// File: tb/tb_isp_uart_rx.sv
// tb_isp_uart_rx: directed bench for isp_uart_rx with CLK_DIV=4 (16 clk per bit).
module tb_isp_uart_rx;

  localparam int unsigned ClkDiv    = 4;
  localparam int unsigned FifoDepth = 4;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] rx_data;
  logic       rx_valid, frame_err, overflow, rx_busy;

  isp_uart_rx #(
    .CLK_DIV   (ClkDiv),
    .FIFO_DEPTH(FifoDepth)
  ) dut (
    .clk      (clk),
    .rstn     (rstn),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .rx_ready (rx_ready),
    .frame_err(frame_err),
    .overflow (overflow),
    .rx_busy  (rx_busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: popped bytes and pulse statistics, sampled on the falling edge.
  logic [7:0] rcv_q[$];
  int ferr_cyc, ovf_cyc, both_cyc, long_cyc, vld_cyc;
  logic ferr_prev = 1'b0;
  logic ovf_prev = 1'b0;

  always @(negedge clk) begin
    if (rstn) begin
      if (rx_valid && rx_ready) rcv_q.push_back(rx_data);
      if (rx_valid) vld_cyc++;
      if (frame_err) ferr_cyc++;
      if (overflow) ovf_cyc++;
      if (frame_err && overflow) both_cyc++;
      if ((frame_err && ferr_prev) || (overflow && ovf_prev)) long_cyc++;
    end
    ferr_prev = frame_err;
    ovf_prev  = overflow;
  end

  task automatic clear_counts();
    rcv_q.delete();
    ferr_cyc = 0;
    ovf_cyc  = 0;
    vld_cyc  = 0;
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode 0: 16 clk bits; mode 1: slow, 17/16 alternating; mode 2: fast, three 15-clk bits.
  function automatic int bit_len(input int mode, input int k);
    if (mode == 1) return (k % 2 == 0) ? 17 : 16;
    if (mode == 2) return (k == 1 || k == 4 || k == 7) ? 15 : 16;
    return 16;
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic stop, input int mode,
                            input logic tail);
    rx = 1'b0;
    wait_clk(bit_len(mode, 0));
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      wait_clk(bit_len(mode, i + 1));
    end
    rx = stop;
    wait_clk(bit_len(mode, 9));
    rx = tail;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_bytes;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[6];
  logic [7:0] exp_b[6];

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{8'hA5, 1'b1, 1, 0};
    vecs[1] = '{8'h00, 1'b1, 1, 0};
    vecs[2] = '{8'hFF, 1'b1, 1, 0};
    vecs[3] = '{8'h80, 1'b1, 1, 0};
    vecs[4] = '{8'h3C, 1'b0, 0, 1};
    vecs[5] = '{8'h7E, 1'b1, 1, 0};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst rx_data", rx_data, 8'h00);
    check("rst rx_valid", rx_valid, 1'b0);
    check("rst frame_err", frame_err, 1'b0);
    check("rst overflow", overflow, 1'b0);
    check("rst rx_busy", rx_busy, 1'b1);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    check("post-rst busy", rx_busy, 1'b1);
    wait_clk(8);
    check("idle busy", rx_busy, 1'b0);

    // Table: single nominal frames with rx_ready held high
    for (int i = 0; i < 6; i++) begin
      clear_counts();
      send_frame(vecs[i].data, vecs[i].stop, 0, 1'b1);
      wait_clk(32);
      check($sformatf("v%0d bytes", i), rcv_q.size(), vecs[i].exp_bytes);
      if (vecs[i].exp_bytes != 0 && rcv_q.size() != 0)
        check($sformatf("v%0d data", i), rcv_q[0], vecs[i].data);
      check($sformatf("v%0d valid cycles", i), vld_cyc, vecs[i].exp_bytes);
      check($sformatf("v%0d frame_err", i), ferr_cyc, vecs[i].exp_ferr);
      check($sformatf("v%0d overflow", i), ovf_cyc, 0);
      check($sformatf("v%0d busy", i), rx_busy, 1'b0);
    end

    // False start: 3 clk low glitch
    clear_counts();
    rx = 1'b0;
    wait_clk(3);
    rx = 1'b1;
    wait_clk(4);
    check("glitch busy in start", rx_busy, 1'b1);
    wait_clk(20);
    check("glitch busy after", rx_busy, 1'b0);
    check("glitch bytes", rcv_q.size(), 0);
    check("glitch valid", vld_cyc, 0);

    // Framing error with the line left low, then recovery
    clear_counts();
    send_frame(8'h3C, 1'b0, 0, 1'b0);
    wait_clk(32);
    check("ferr pulses", ferr_cyc, 1);
    check("ferr busy while low", rx_busy, 1'b1);
    check("ferr no byte", rcv_q.size(), 0);
    rx = 1'b1;
    wait_clk(32);
    check("ferr recovered idle", rx_busy, 1'b0);
    send_frame(8'h5A, 1'b1, 0, 1'b1);
    wait_clk(32);
    check("after ferr bytes", rcv_q.size(), 1);
    if (rcv_q.size() != 0) check("after ferr data", rcv_q[0], 8'h5A);
    check("after ferr pulses", ferr_cyc, 1);

    // Overflow: five bytes into a four-entry FIFO with no consumer
    clear_counts();
    rx_ready = 1'b0;
    for (int b = 1; b <= 4; b++) begin
      send_frame(8'(b), 1'b1, 0, 1'b1);
      wait_clk(8);
    end
    check("ovf before 5th", ovf_cyc, 0);
    send_frame(8'h05, 1'b1, 0, 1'b1);
    wait_clk(8);
    check("ovf pulses", ovf_cyc, 1);
    check("ovf head valid", rx_valid, 1'b1);
    check("ovf head data", rx_data, 8'h01);
    rx_ready = 1'b1;
    wait_clk(10);
    check("ovf drained bytes", rcv_q.size(), 4);
    for (int k = 0; k < 4; k++) begin
      if (rcv_q.size() > k) check($sformatf("ovf byte %0d", k), rcv_q[k], 8'(k + 1));
    end
    check("ovf empty after", rx_valid, 1'b0);

    // Back-to-back frames with skewed bit periods
    clear_counts();
    exp_b = '{8'h55, 8'hFF, 8'h00, 8'h55, 8'hFF, 8'h00};
    for (int k = 0; k < 3; k++) send_frame(exp_b[k], 1'b1, 2, 1'b1);
    wait_clk(32);
    for (int k = 3; k < 6; k++) send_frame(exp_b[k], 1'b1, 1, 1'b1);
    wait_clk(32);
    check("skew bytes", rcv_q.size(), 6);
    for (int k = 0; k < 6; k++) begin
      if (rcv_q.size() > k) check($sformatf("skew byte %0d", k), rcv_q[k], exp_b[k]);
    end
    check("skew frame_err", ferr_cyc, 0);
    check("skew overflow", ovf_cyc, 0);

    // Reset in the middle of a byte, line held low after release
    clear_counts();
    rx = 1'b0;
    wait_clk(16);
    for (int i = 0; i < 4; i++) begin
      rx = ~rx;
      wait_clk(16);
    end
    rstn = 1'b0;
    @(negedge clk);
    check("midrst rx_data", rx_data, 8'h00);
    check("midrst rx_valid", rx_valid, 1'b0);
    check("midrst frame_err", frame_err, 1'b0);
    check("midrst overflow", overflow, 1'b0);
    check("midrst rx_busy", rx_busy, 1'b1);
    rx = 1'b0;
    wait_clk(3);
    rstn = 1'b1;
    wait_clk(40);
    check("low after rst busy", rx_busy, 1'b1);
    check("low after rst bytes", rcv_q.size(), 0);
    rx = 1'b1;
    wait_clk(20);
    check("rst recovered idle", rx_busy, 1'b0);
    send_frame(8'h81, 1'b1, 0, 1'b1);
    wait_clk(32);
    check("post-rst bytes", rcv_q.size(), 1);
    if (rcv_q.size() != 0) check("post-rst data", rcv_q[0], 8'h81);
    check("post-rst frame_err", ferr_cyc, 0);

    check("err and ovf together", both_cyc, 0);
    check("pulses wider than 1", long_cyc, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
